// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings,
// FSM state enum and the alignment rules used by the FSM and the lane aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } lsu_state_e;

  // The reserved encoding 2'b11 behaves exactly like a word access.
  function automatic lsu_size_e norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : lsu_size_e'(sz);
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits a half/word access is not allowed to use.
  function automatic logic [1:0] align_lo(input lsu_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational little-endian lane logic: extracts and sign/zero-extends the
// load lane of a memory word, and merges the store lane into a memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and infers a latch.
    byte_sel     = word_i[{lane_i, 3'b000} +: 8];
    half_sel     = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o  = word_i;
    merge_data_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_data_o = word_i;
        merge_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_data_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_data_o = lane_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                 : {word_i[31:16], wdata_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding FSM (IDLE/RD/WR/RSP) with read-modify-write
// for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  lsu_size_e         size_q;
  logic              uns_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  lsu_size_e         req_size_n;
  logic              accept;
  logic              misalign_req;
  logic              misalign_q;
  logic [MEM_AW-1:0] accept_addr;
  logic [MEM_AW-1:0] word_addr;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign req_size_n = norm_size(req_size);
  assign accept     = req_valid && (state_q == IDLE);
  assign word_addr  = {addr_q[MEM_AW-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_req = is_misaligned(req_size_n, req_addr[1:0]);
  assign misalign_q   = is_misaligned(size_q, addr_q[1:0]);
  assign accept_addr  = req_addr;
`else
  // Misaligned requests are silently rounded down and treated as aligned.
  assign misalign_req = 1'b0;
  assign misalign_q   = 1'b0;
  assign accept_addr  = {req_addr[MEM_AW-1:2], align_lo(req_size_n, req_addr[1:0])};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: request fields are cleared on reset too, so nothing downstream ever
  // sees an X even before the first request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size_n;
        uns_q   <= req_unsigned;
        addr_q  <= accept_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RD) word_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (misalign_req)              state_d = RSP;
        else if (!req_we)              state_d = RD;
        else if (req_size_n == SZ_WORD) state_d = WR;
        else                           state_d = RD;
      end
      RD:      state_d = we_q ? WR : RSP;
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      RD: begin
        MemRead  = 1'b1;
        mem_addr = word_addr;
      end
      WR: begin
        MemWrite  = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = merge_data;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = misalign_q;
        if (!we_q && !misalign_q) rsp_rdata = load_data;
      end
      default: ;
    endcase
  end

  lsu_lane_align u_lane_align (
    .word_i       (word_q),
    .wdata_i      (wdata_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .lane_i       (addr_q[1:0]),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of directed accesses against a
// small word memory, plus reset-during-write and back-to-back request sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Word-organised memory model: combinational read, write on rising edge.
  logic [31:0] mem [0:63];
  assign mem_rdata = MemRead ? mem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) if (MemWrite) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] init;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic we, logic [1:0] size, logic uns,
                              logic [31:0] addr, logic [31:0] init, logic [31:0] wdata,
                              logic [31:0] exp_rdata, logic exp_err, int exp_lat,
                              int exp_rd, int exp_wr, logic [31:0] exp_mem);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.init = init; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_mem = exp_mem;
    return v;
  endfunction

  // Called right after the accept edge; samples on falling edges until rsp_valid.
  task automatic wait_rsp(input logic [31:0] exp_maddr, output int lat, output int rd,
                          output int wr, output int bad, output logic [31:0] rdata,
                          output logic err);
    bit got = 0;
    lat = 1; rd = 0; wr = 0; bad = 0; rdata = '0; err = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (MemRead) rd++;
      if (MemWrite) wr++;
      if (MemRead && MemWrite) bad++;
      if ((MemRead || MemWrite) && mem_addr !== exp_maddr) bad++;
      if (rsp_valid) begin
        got = 1;
        rdata = rsp_rdata;
        err = rsp_err;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) lat = 99;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, rd, wr, bad;
    logic [31:0] rdata;
    logic err;
    mem[v.addr[7:2]] = v.init;
    @(negedge clk);
    check({v.name, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp({v.addr[31:2], 2'b00}, lat, rd, wr, bad, rdata, err);
    check({v.name, "_lat"},   lat, v.exp_lat);
    check({v.name, "_rdata"}, rdata, v.exp_rdata);
    check({v.name, "_err"},   {31'b0, err}, {31'b0, v.exp_err});
    check({v.name, "_rd"},    rd, v.exp_rd);
    check({v.name, "_wr"},    wr, v.exp_wr);
    check({v.name, "_bus"},   bad, 0);
    check({v.name, "_mem"},   mem[v.addr[7:2]], v.exp_mem);
  endtask

  initial begin
    int lat, rd, wr, bad, rdy_hi;
    logic [31:0] rdata;
    logic err;

    for (int i = 0; i < 64; i++) mem[i] = '0;

    //          name      we  size  uns  addr   init          wdata         rdata         err lat rd wr mem
    vecs.push_back(mk("lw40",  0, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lb43",  0, 2'b00, 0, 32'h43, 32'hDEADBEEF, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lbu43", 0, 2'b00, 1, 32'h43, 32'hDEADBEEF, 32'h0,        32'h000000DE, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lh42",  0, 2'b01, 0, 32'h42, 32'hDEADBEEF, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lb41",  0, 2'b00, 0, 32'h41, 32'hDEADBEEF, 32'h0,        32'hFFFFFFBE, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lhu40", 0, 2'b01, 1, 32'h40, 32'hDEADBEEF, 32'h0,        32'h0000BEEF, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lb45",  0, 2'b00, 0, 32'h45, 32'h12345678, 32'h0,        32'h00000056, 0, 2, 1, 0, 32'h12345678));
    vecs.push_back(mk("lh46",  0, 2'b01, 0, 32'h46, 32'h12345678, 32'h0,        32'h00001234, 0, 2, 1, 0, 32'h12345678));
    vecs.push_back(mk("lrsv",  0, 2'b11, 0, 32'h40, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("sb41",  1, 2'b00, 0, 32'h41, 32'hDEADBEEF, 32'h00000012, 32'h0,        0, 3, 1, 1, 32'hDEAD12EF));
    vecs.push_back(mk("sb43",  1, 2'b00, 0, 32'h43, 32'hDEADBEEF, 32'hFFFFFF77, 32'h0,        0, 3, 1, 1, 32'h77ADBEEF));
    vecs.push_back(mk("sh42",  1, 2'b01, 0, 32'h42, 32'hDEADBEEF, 32'hAAAA5566, 32'h0,        0, 3, 1, 1, 32'h5566BEEF));
    vecs.push_back(mk("sw44",  1, 2'b10, 0, 32'h44, 32'h11111111, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 32'hCAFEF00D));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw42m", 0, 2'b10, 0, 32'h42, 32'hDEADBEEF, 32'h0,        32'h0,        1, 1, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk("sh43m", 1, 2'b01, 0, 32'h43, 32'hDEADBEEF, 32'h00001234, 32'h0,        1, 1, 0, 0, 32'hDEADBEEF));
`else
    vecs.push_back(mk("lw42m", 0, 2'b10, 0, 32'h42, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk("sh43m", 1, 2'b01, 0, 32'h43, 32'hDEADBEEF, 32'h00001234, 32'h0,        0, 3, 1, 1, 32'h1234BEEF));
`endif

    // Reset state while rst_n is held low.
    #12;
    check("rst_ready",  {31'b0, req_ready}, 32'd1);
    check("rst_rvalid", {31'b0, rsp_valid}, 32'd0);
    check("rst_strobe", {30'b0, MemRead, MemWrite}, 32'd0);
    check("rst_maddr",  mem_addr, 32'h0);
    check("rst_wdata",  mem_wdata, 32'h0);
    check("rst_rdata",  rsp_rdata, 32'h0);
    check("rst_err",    {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted in the middle of the WR cycle of a half store.
    mem[16] = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h00009999;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 6 && !MemWrite; i++) @(negedge clk);
    check("rstwr_reached", {31'b0, MemWrite}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_memwrite", {31'b0, MemWrite}, 32'd0);
    check("rstwr_ready",    {31'b0, req_ready}, 32'd1);
    check("rstwr_rvalid",   {31'b0, rsp_valid}, 32'd0);
    check("rstwr_maddr",    mem_addr, 32'h0);
    check("rstwr_wdata",    mem_wdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rstwr_mem",      mem[16], 32'hDEADBEEF);
    check("rstwr_rvalid2",  {31'b0, rsp_valid}, 32'd0);
    // Release and present a load in the same cycle: it must be taken on the next edge.
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rstrel_busy", {31'b0, req_ready}, 32'd0);
    wait_rsp(32'h40, lat, rd, wr, bad, rdata, err);
    check("rstrel_lat",   lat, 2);
    check("rstrel_rdata", rdata, 32'hDEADBEEF);

    // Back-to-back: req_valid stays high; the second request must wait for IDLE.
    mem[17] = 32'h0BADF00D;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40;
    @(posedge clk);
    #1 req_addr = 32'h44;
    rdy_hi = 0;
    lat = 1; rdata = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready) rdy_hi++;
      if (rsp_valid) begin
        rdata = rsp_rdata;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check("b2b_first_lat",   lat, 2);
    check("b2b_first_rdata", rdata, 32'hDEADBEEF);
    check("b2b_ready_low",   rdy_hi, 0);
    @(negedge clk);
    check("b2b_idle_ready",  {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("b2b_second_busy", {31'b0, req_ready}, 32'd0);
    wait_rsp(32'h44, lat, rd, wr, bad, rdata, err);
    check("b2b_second_lat",   lat, 2);
    check("b2b_second_rdata", rdata, 32'h0BADF00D);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 32, meaning width of mem_addr and req_addr.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core requests an access.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr  input  MEM_AW  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores.
REQ-013 SHALL have port rsp_err  output  1  misaligned access, qualified by rsp_valid.
REQ-014 SHALL have ports MemRead and MemWrite  output  1 each  data-memory strobes.
REQ-015 SHALL have port mem_addr  output  MEM_AW  word-aligned byte address; low 2 bits always 0.
REQ-016 SHALL have ports mem_wdata  output  32 and mem_rdata  input  32.  Memory read is combinational while MemRead=1; memory write occurs at the rising edge while MemWrite=1.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR, RSP; req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge when req_valid=1 and state IDLE, latching all req_* fields; req_* are ignored otherwise.
REQ-019 SHALL transition as follows: load IDLE->RD->RSP; word store IDLE->WR->RSP; byte/half store IDLE->RD->WR->RSP (read-modify-write); misaligned IDLE->RSP; RSP->IDLE always.
REQ-020 SHALL give rsp_valid latencies from the accept edge of 2 cycles for load, 2 for word store, 3 for sub-word store, and 1 for misaligned.
REQ-021 SHALL assert MemRead only in RD and MemWrite only in WR, never both, and hold mem_addr = {addr[MEM_AW-1:2],2'b00} during both.
REQ-022 SHALL capture mem_rdata into an internal word register at the end of RD.
REQ-023 SHALL use little-endian lane selection: byte lane addr[1:0], half lane addr[1].
REQ-024 SHALL merge the store lane of req_wdata into the captured word in WR for sub-word stores, leaving other bytes unchanged.
REQ-025 SHALL classify half with addr[0]=1, and word with addr[1:0]!=0, as misaligned.
REQ-026 SHALL drive rsp_rdata, rsp_err, MemRead, MemWrite, mem_wdata to 0 outside the states where they are defined.

Reset
REQ-027 SHALL on rst_n=0 immediately enter IDLE and drive req_ready=1 and rsp_valid, rsp_err, MemRead, MemWrite, mem_addr, mem_wdata, rsp_rdata to 0.
REQ-028 SHALL abandon any in-flight access on reset with no memory write and no response; a request is accepted on the first edge after release.

Configuration
REQ-029 SHALL honour macro LSU_MISALIGN_TRAP_EN: when defined, misaligned requests follow REQ-025 and REQ-019, with no memory access and rsp_err=1.
REQ-030 SHALL, when LSU_MISALIGN_TRAP_EN is undefined, force addr[0] to 0 for half accesses and addr[1:0] to 0 for word accesses, proceed as aligned, and tie rsp_err to 0.

Structure
REQ-031 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum in shared package lsu_pkg.
REQ-032 SHALL place the combinational lane extract/extend and lane merge in sub-module lsu_lane_align; the FSM and registers reside in load_store_unit.

Verification
REQ-033 SHALL cover: word 0xDEADBEEF pre-loaded at 0x40, load word 0x40 -> MemRead for exactly 1 cycle, rsp_rdata=0xDEADBEEF 2 cycles after accept.
REQ-034 SHALL cover: same word, lb 0x43 signed -> 0xFFFFFFDE; lbu 0x43 -> 0x000000DE; lh 0x42 signed -> 0xFFFFDEAD.
REQ-035 SHALL cover: sb 0x41 data 0x12 onto 0xDEADBEEF -> one RD cycle, one WR cycle, memory word 0xDEAD12EF, rsp_valid 3 cycles after accept.
REQ-036 SHALL cover: with LSU_MISALIGN_TRAP_EN, lw 0x42 -> rsp_valid with rsp_err=1 1 cycle after accept, MemRead and MemWrite never asserted; without the macro -> word at 0x40 returned with rsp_err=0.
REQ-037 SHALL cover: rst_n pulsed low during WR of sh 0x40 -> MemWrite drops immediately, memory unchanged, no rsp_valid, req_ready=1.
REQ-038 SHALL cover: req_valid held high for back-to-back requests -> the second is accepted only on the edge after RSP, req_ready=0 throughout.
